// File: rtl/cmp_sample_sequencer.sv
// cmp_sample_sequencer: clear / wait / settle / sample / majority-vote sequencer for a latched comparator.
// All outputs are registered from the current state and therefore trail the state register by one cycle.
`default_nettype none

module cmp_sample_sequencer #(
  parameter int RST_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int NSAMP         = 5,
  parameter int TIMEOUT       = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       cmp_out,
  input  logic                       cmp_done,
  output logic                       cmp_clr,
  output logic                       busy,
  output logic                       result,
  output logic                       result_valid,
  output logic                       timeout,
  output logic [$clog2(NSAMP+1)-1:0] ones_cnt
);

  localparam int OW     = $clog2(NSAMP + 1);
  localparam int MAX_A  = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int MAX_B  = (NSAMP > TIMEOUT) ? NSAMP : TIMEOUT;
  localparam int MAXCNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW     = $clog2(MAXCNT + 1);

  localparam logic [CW-1:0] CLEAR_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(NSAMP - 1);
  localparam logic [OW-1:0] HALF        = OW'(NSAMP / 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    WAIT   = 3'd2,
    SETTLE = 3'd3,
    SAMPLE = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [OW-1:0]   ones;
  logic            abort;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      ones         <= '0;
      abort        <= 1'b0;
      cmp_clr      <= 1'b1;
      busy         <= 1'b0;
      result       <= 1'b0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      ones_cnt     <= '0;
    end else begin
      cmp_clr      <= (state == IDLE) || (state == CLEAR) || (state == DONE);
      busy         <= (state != IDLE);
      result_valid <= (state == DONE);
      timeout      <= (state == DONE) && abort;
      // result and ones_cnt hold their value until the next DONE
      if (state == DONE) begin
        result   <= !abort && (ones > HALF);
        ones_cnt <= ones;
      end

      case (state)
        IDLE: begin
          cnt   <= '0;
          ones  <= '0;
          abort <= 1'b0;
          if (start) state <= CLEAR;
        end
        CLEAR: begin
          if (cnt == CLEAR_LAST) begin
            cnt   <= '0;
            state <= WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT: begin
          if (cmp_done) begin
            cnt   <= '0;
            state <= SETTLE;
          end else if (cnt == WAIT_LAST) begin
            abort <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETTLE: begin
          // a dropped decision flag means the comparator lost its result
          if (!cmp_done) begin
            abort <= 1'b1;
            state <= DONE;
          end else if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= SAMPLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SAMPLE: begin
          if (!cmp_done) begin
            abort <= 1'b1;
            state <= DONE;
          end else begin
            ones <= ones + OW'(cmp_out);
            if (cnt == SAMPLE_LAST) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
